// File: rtl/sys_arr_pkg.sv
// Shared definitions for the systolic-array dispatch slice: default sizes,
// the per-array weight-load state and the writeback tag type.
package sys_arr_pkg;

    localparam int NUM_SA_DEF      = 2;
    localparam int ROW_W_DEF       = 512;
    localparam int WEIGHT_ROWS_DEF = 32;
    localparam int VEGGIEREGS_DEF  = 256;
    localparam int TAG_DEPTH_DEF   = 64;
    localparam int ENTRY_BITS_DEF  = $clog2(VEGGIEREGS_DEF);

    // Weight-load progress of one systolic array.
    typedef enum logic [1:0] {
        WGT_NOWGT   = 2'b00,
        WGT_LOADING = 2'b01,
        WGT_READY   = 2'b10
    } wgt_state_e;

    // Destination register carried alongside each in-flight input op.
    typedef logic [ENTRY_BITS_DEF-1:0] tag_t;

endpackage

// File: rtl/gsau_tag_fifo.sv
// Register-based tag FIFO holding the destination register of every input op
// still inside one systolic array. Head entry is visible combinationally on
// dout so the writeback can use it in the cycle the result appears.
// full/empty are registered; a pop frees space only from the next cycle.
module gsau_tag_fifo
    import sys_arr_pkg::*;
#(
    parameter int WIDTH = ENTRY_BITS_DEF,
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;
    assign dout      = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
        end
    end

    // Tag storage; contents are meaningless while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/gsau_multi_dispatch.sv
// Dispatches scoreboard issues to NUM_SA systolic arrays and arbitrates their
// results back to a single writeback port. Each array tracks its weight load
// and keeps a tag FIFO of destination registers for ops still in flight.
module gsau_multi_dispatch
    import sys_arr_pkg::*;
#(
    parameter int VEGGIEREGS  = VEGGIEREGS_DEF,
    parameter int NUM_SA      = NUM_SA_DEF,
    parameter int ROW_W       = ROW_W_DEF,
    parameter int WEIGHT_ROWS = WEIGHT_ROWS_DEF,
    parameter int TAG_DEPTH   = TAG_DEPTH_DEF,
    parameter int ENTRY_BITS  = $clog2(VEGGIEREGS),
    parameter int SEL_W       = $clog2(NUM_SA)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    sb_valid,
    output logic                    sb_ready,
    input  logic                    sb_weight,
    input  logic                    sb_accum,
    input  logic [SEL_W-1:0]        sb_sa_sel,
    input  logic [ENTRY_BITS-1:0]   sb_vdst,
    input  logic [ROW_W-1:0]        veg_vdata1,
    input  logic [ROW_W-1:0]        veg_vdata2,
    output logic [ROW_W-1:0]        sa_array_in,
    output logic [ROW_W-1:0]        sa_array_in_partials,
    output logic [NUM_SA-1:0]       sa_input_en,
    output logic [NUM_SA-1:0]       sa_weight_en,
    output logic [NUM_SA-1:0]       sa_partial_en,
    input  logic [NUM_SA-1:0]       sa_fifo_has_space,
    input  logic [NUM_SA-1:0]       sa_out_valid,
    input  logic [NUM_SA*ROW_W-1:0] sa_array_output,
    output logic [NUM_SA-1:0]       sa_output_ready,
    output logic                    wb_valid,
    input  logic                    wb_output_ready,
    output logic [ENTRY_BITS-1:0]   wb_wbdst,
    output logic [ROW_W-1:0]        wb_psum,
    output logic [SEL_W-1:0]        wb_sa_id,
    output logic [NUM_SA-1:0]       sa_weights_ready,
    output logic                    err_orphan
);

    localparam int CNT_W = $clog2(WEIGHT_ROWS + 1);

    logic [NUM_SA-1:0]            wgt_ok_s;
    logic [NUM_SA-1:0]            inp_ok_s;
    logic [NUM_SA-1:0]            tag_full_s;
    logic [NUM_SA-1:0]            tag_empty_s;
    logic [NUM_SA-1:0]            pop_s;
    logic [NUM_SA-1:0]            cand_s;
    logic [NUM_SA-1:0]            orphan_s;
    logic [NUM_SA*ENTRY_BITS-1:0] tag_dout_s;
    logic [SEL_W-1:0]             rr_ptr_r;
    logic [SEL_W-1:0]             grant_s;
    logic [SEL_W-1:0]             idx_s;
    logic                         any_cand_s;
    logic                         accept_s;
    logic                         xfer_s;
    logic                         err_orphan_r;

    // Broadcast data; partials are zeroed for non-accumulating ops.
    assign sa_array_in          = veg_vdata1;
    assign sa_array_in_partials = sb_accum ? veg_vdata2 : {ROW_W{1'b0}};

    // Issue acceptance: target array must have space and accept this op class.
    always_comb begin
        sb_ready = 1'b0;
        if (!nRST) begin
            sb_ready = 1'b0;
        end else if (sb_weight) begin
            sb_ready = sa_fifo_has_space[sb_sa_sel] & wgt_ok_s[sb_sa_sel];
        end else begin
            sb_ready = sa_fifo_has_space[sb_sa_sel] & inp_ok_s[sb_sa_sel];
        end
    end

    assign accept_s = sb_valid & sb_ready;

    // One-hot per-array strobes for the accepted op, same cycle as handshake.
    always_comb begin
        sa_weight_en  = '0;
        sa_input_en   = '0;
        sa_partial_en = '0;
        if (accept_s) begin
            if (sb_weight) begin
                sa_weight_en[sb_sa_sel] = 1'b1;
            end else begin
                sa_input_en[sb_sa_sel]   = 1'b1;
                sa_partial_en[sb_sa_sel] = 1'b1;
            end
        end else begin
            sa_weight_en  = '0;
            sa_input_en   = '0;
            sa_partial_en = '0;
        end
    end

    for (genvar i = 0; i < NUM_SA; i++) begin : g_sa
        wgt_state_e       state_r;
        wgt_state_e       state_nxt_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_nxt_s;
        logic             wgt_ok_l_s;
        logic             inp_ok_l_s;
        logic             rdy_l_s;

        // Weight-load state and beat count register.
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                state_r <= WGT_NOWGT;
                cnt_r   <= '0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
            end
        end

        // Weight-load next state; a new load restarts at beat one.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            case (state_r)
                WGT_NOWGT, WGT_READY: begin
                    if (sa_weight_en[i]) begin
                        cnt_nxt_s   = CNT_W'(1);
                        state_nxt_s = (WEIGHT_ROWS == 1) ? WGT_READY : WGT_LOADING;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                WGT_LOADING: begin
                    if (sa_weight_en[i]) begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                        if ((cnt_r + CNT_W'(1)) == CNT_W'(WEIGHT_ROWS)) begin
                            state_nxt_s = WGT_READY;
                        end else begin
                            state_nxt_s = WGT_LOADING;
                        end
                    end else begin
                        state_nxt_s = WGT_LOADING;
                    end
                end
                default: begin
                    state_nxt_s = WGT_NOWGT;
                    cnt_nxt_s   = '0;
                end
            endcase
        end

        // Op classes this array will take; weights only reload once drained.
        always_comb begin
            wgt_ok_l_s = 1'b0;
            inp_ok_l_s = 1'b0;
            rdy_l_s    = 1'b0;
            case (state_r)
                WGT_NOWGT:   wgt_ok_l_s = 1'b1;
                WGT_LOADING: wgt_ok_l_s = 1'b1;
                WGT_READY: begin
                    wgt_ok_l_s = tag_empty_s[i];
                    inp_ok_l_s = ~tag_full_s[i];
                    rdy_l_s    = 1'b1;
                end
                default: begin
                    wgt_ok_l_s = 1'b0;
                    inp_ok_l_s = 1'b0;
                    rdy_l_s    = 1'b0;
                end
            endcase
        end

        assign wgt_ok_s[i]         = wgt_ok_l_s;
        assign inp_ok_s[i]         = inp_ok_l_s;
        assign sa_weights_ready[i] = rdy_l_s;
        assign cand_s[i]           = sa_out_valid[i] & ~tag_empty_s[i];
        assign orphan_s[i]         = sa_out_valid[i] & tag_empty_s[i];

        gsau_tag_fifo #(
            .WIDTH (ENTRY_BITS),
            .DEPTH (TAG_DEPTH)
        ) u_tag_fifo (
            .clk   (CLK),
            .rst_n (nRST),
            .push  (sa_input_en[i]),
            .pop   (pop_s[i]),
            .din   (sb_vdst),
            .dout  (tag_dout_s[i*ENTRY_BITS +: ENTRY_BITS]),
            .full  (tag_full_s[i]),
            .empty (tag_empty_s[i])
        );
    end

    // Round-robin grant among arrays with a result and a matching tag.
    always_comb begin
        grant_s    = rr_ptr_r;
        any_cand_s = 1'b0;
        idx_s      = rr_ptr_r;
        for (int k = 0; k < NUM_SA; k++) begin
            idx_s = rr_ptr_r + SEL_W'(k);
            if (!any_cand_s && cand_s[idx_s]) begin
                any_cand_s = 1'b1;
                grant_s    = idx_s;
            end else begin
                any_cand_s = any_cand_s;
            end
        end
    end

    assign xfer_s   = any_cand_s & wb_output_ready;
    assign wb_valid = any_cand_s;
    assign wb_sa_id = grant_s;
    assign wb_wbdst = tag_dout_s[grant_s*ENTRY_BITS +: ENTRY_BITS];
    assign wb_psum  = sa_array_output[grant_s*ROW_W +: ROW_W];
    assign err_orphan = err_orphan_r;

    // Tag pop for the array whose result is written back this cycle.
    always_comb begin
        pop_s = '0;
        if (xfer_s) begin
            pop_s[grant_s] = 1'b1;
        end else begin
            pop_s = '0;
        end
    end

    // Result consumption: granted transfer, or drop of an untagged result.
    always_comb begin
        sa_output_ready = '0;
        if (nRST) begin
            sa_output_ready = orphan_s;
            if (xfer_s) begin
                sa_output_ready[grant_s] = wb_output_ready;
            end
        end else begin
            sa_output_ready = '0;
        end
    end

    // Arbiter priority pointer moves past the winner on each transfer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_r <= '0;
        end else if (xfer_s) begin
            rr_ptr_r <= grant_s + SEL_W'(1);
        end
    end

    // Sticky flag for results that arrived with no tag outstanding.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_orphan_r <= 1'b0;
        end else if (|orphan_s) begin
            err_orphan_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gsau_multi_dispatch.sv
// Directed bench for gsau_multi_dispatch with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_gsau_multi_dispatch;

    localparam int NS = 2;
    localparam int RW = 32;
    localparam int WR = 4;
    localparam int TD = 4;
    localparam int ST_NOWGT = 0;
    localparam int ST_LOADING = 1;
    localparam int ST_READY = 2;

    logic          clk;
    logic          nRST;
    logic          sb_valid;
    logic          sb_ready;
    logic          sb_weight;
    logic          sb_accum;
    logic [0:0]    sb_sa_sel;
    logic [7:0]    sb_vdst;
    logic [RW-1:0] veg_vdata1;
    logic [RW-1:0] veg_vdata2;
    logic [RW-1:0] sa_array_in;
    logic [RW-1:0] sa_array_in_partials;
    logic [NS-1:0] sa_input_en;
    logic [NS-1:0] sa_weight_en;
    logic [NS-1:0] sa_partial_en;
    logic [NS-1:0] sa_fifo_has_space;
    logic [NS-1:0] sa_out_valid;
    logic [NS*RW-1:0] sa_array_output;
    logic [NS-1:0] sa_output_ready;
    logic          wb_valid;
    logic          wb_output_ready;
    logic [7:0]    wb_wbdst;
    logic [RW-1:0] wb_psum;
    logic [0:0]    wb_sa_id;
    logic [NS-1:0] sa_weights_ready;
    logic          err_orphan;

    int checks;
    int errors;

    // reference model state
    int m_st [NS];
    int m_cnt [NS];
    int m_q0 [$];
    int m_q1 [$];
    int m_rr;
    bit m_err;

    gsau_multi_dispatch #(
        .VEGGIEREGS (256),
        .NUM_SA     (NS),
        .ROW_W      (RW),
        .WEIGHT_ROWS(WR),
        .TAG_DEPTH  (TD)
    ) dut (
        .CLK                 (clk),
        .nRST                (nRST),
        .sb_valid            (sb_valid),
        .sb_ready            (sb_ready),
        .sb_weight           (sb_weight),
        .sb_accum            (sb_accum),
        .sb_sa_sel           (sb_sa_sel),
        .sb_vdst             (sb_vdst),
        .veg_vdata1          (veg_vdata1),
        .veg_vdata2          (veg_vdata2),
        .sa_array_in         (sa_array_in),
        .sa_array_in_partials(sa_array_in_partials),
        .sa_input_en         (sa_input_en),
        .sa_weight_en        (sa_weight_en),
        .sa_partial_en       (sa_partial_en),
        .sa_fifo_has_space   (sa_fifo_has_space),
        .sa_out_valid        (sa_out_valid),
        .sa_array_output     (sa_array_output),
        .sa_output_ready     (sa_output_ready),
        .wb_valid            (wb_valid),
        .wb_output_ready     (wb_output_ready),
        .wb_wbdst            (wb_wbdst),
        .wb_psum             (wb_psum),
        .wb_sa_id            (wb_sa_id),
        .sa_weights_ready    (sa_weights_ready),
        .err_orphan          (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? m_q0.size() : m_q1.size();
    endfunction

    function automatic int qfront(input int i);
        return (i == 0) ? m_q0[0] : m_q1[0];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_st[i]  = ST_NOWGT;
            m_cnt[i] = 0;
        end
        m_q0.delete();
        m_q1.delete();
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    // Model: derive every output from the rules, compare, then advance at the edge.
    initial begin : model
        bit e_rdy;
        bit hs;
        bit found;
        bit w;
        int sel;
        int g;
        int vd;
        int idx;
        logic [NS-1:0] orph;
        logic [NS-1:0] e_or;
        logic [NS-1:0] e_we;
        logic [NS-1:0] e_ie;
        logic [NS-1:0] e_wr;
        m_reset();
        forever begin
            @(negedge clk);
            hs = 1'b0;
            found = 1'b0;
            orph = '0;
            g = 0;
            sel = 0;
            w = 1'b0;
            vd = 0;
            if (!nRST) begin
                m_reset();
                check("rst_sb_ready", 64'(sb_ready), 64'(0));
                check("rst_en", 64'({sa_weight_en, sa_input_en, sa_partial_en}), 64'(0));
                check("rst_out_ready", 64'(sa_output_ready), 64'(0));
                check("rst_wb_valid", 64'(wb_valid), 64'(0));
                check("rst_wready", 64'(sa_weights_ready), 64'(0));
                check("rst_err", 64'(err_orphan), 64'(0));
            end else begin
                sel = int'(sb_sa_sel);
                w = sb_weight;
                vd = int'(sb_vdst);
                if (w) e_rdy = sa_fifo_has_space[sel] && (m_st[sel] != ST_READY || qsize(sel) == 0);
                else e_rdy = sa_fifo_has_space[sel] && m_st[sel] == ST_READY && qsize(sel) < TD;
                hs = sb_valid && e_rdy;
                e_we = '0;
                e_ie = '0;
                if (hs) begin
                    if (w) e_we[sel] = 1'b1;
                    else e_ie[sel] = 1'b1;
                end
                for (int k = 0; k < NS; k++) begin
                    idx = (m_rr + k) % NS;
                    if (!found && sa_out_valid[idx] && qsize(idx) > 0) begin
                        found = 1'b1;
                        g = idx;
                    end
                end
                for (int i = 0; i < NS; i++) begin
                    orph[i] = sa_out_valid[i] && qsize(i) == 0;
                    e_wr[i] = (m_st[i] == ST_READY);
                end
                e_or = orph;
                if (found && wb_output_ready) e_or[g] = 1'b1;
                check("sb_ready", 64'(sb_ready), 64'(e_rdy));
                check("weight_en", 64'(sa_weight_en), 64'(e_we));
                check("input_en", 64'(sa_input_en), 64'(e_ie));
                check("partial_en", 64'(sa_partial_en), 64'(e_ie));
                check("array_in", 64'(sa_array_in), 64'(veg_vdata1));
                check("partials", 64'(sa_array_in_partials), 64'(sb_accum ? veg_vdata2 : 32'd0));
                check("wb_valid", 64'(wb_valid), 64'(found));
                check("out_ready", 64'(sa_output_ready), 64'(e_or));
                check("weights_ready", 64'(sa_weights_ready), 64'(e_wr));
                check("err_orphan", 64'(err_orphan), 64'(m_err));
                if (found) begin
                    check("wb_wbdst", 64'(wb_wbdst), 64'(qfront(g)));
                    check("wb_sa_id", 64'(wb_sa_id), 64'(g));
                    check("wb_psum", 64'(wb_psum), 64'(sa_array_output[g*RW +: RW]));
                end
            end
            @(posedge clk);
            if (nRST) begin
                if (found && wb_output_ready) begin
                    if (g == 0) void'(m_q0.pop_front());
                    else void'(m_q1.pop_front());
                    m_rr = (g + 1) % NS;
                end
                if (hs) begin
                    if (w) begin
                        if (m_st[sel] == ST_LOADING) m_cnt[sel]++;
                        else m_cnt[sel] = 1;
                        m_st[sel] = (m_cnt[sel] == WR) ? ST_READY : ST_LOADING;
                    end else if (sel == 0) begin
                        m_q0.push_back(vd);
                    end else begin
                        m_q1.push_back(vd);
                    end
                end
                if (|orph) m_err = 1'b1;
            end
        end
    end

    // Present one op and hold it until accepted (bounded), then drop valid.
    task automatic issue(input bit w, input bit acc, input int sel, input int vdst,
                         input logic [RW-1:0] d1, input logic [RW-1:0] d2);
        bit got;
        got = 1'b0;
        sb_valid   = 1'b1;
        sb_weight  = w;
        sb_accum   = acc;
        sb_sa_sel  = sel[0:0];
        sb_vdst    = vdst[7:0];
        veg_vdata1 = d1;
        veg_vdata2 = d2;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sb_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("issue_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        sb_valid = 1'b0;
    endtask

    task automatic set_out(input int i, input logic [RW-1:0] v);
        if (i == 0) sa_array_output[RW-1:0] = v;
        else sa_array_output[2*RW-1:RW] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios with literal expectations.
    initial begin : stim
        int r0;
        int r1;
        checks = 0;
        errors = 0;
        nRST = 1'b0;
        sb_valid = 1'b1;
        sb_weight = 1'b1;
        sb_accum = 1'b0;
        sb_sa_sel = 1'b0;
        sb_vdst = 8'd0;
        veg_vdata1 = 32'h0;
        veg_vdata2 = 32'h0;
        sa_fifo_has_space = 2'b11;
        sa_out_valid = 2'b11;
        sa_array_output = '0;
        wb_output_ready = 1'b1;

        // reset with traffic present
        repeat (2) @(negedge clk);
        check("lit_rst_ready", 64'(sb_ready), 64'(0));
        check("lit_rst_wbv", 64'(wb_valid), 64'(0));
        step();
        nRST = 1'b1;
        sb_valid = 1'b0;
        sa_out_valid = 2'b00;

        // input op to an unloaded array is refused
        sb_valid = 1'b1; sb_weight = 1'b0; sb_sa_sel = 1'b0; sb_vdst = 8'd3;
        @(negedge clk);
        check("lit_nowgt_input", 64'(sb_ready), 64'(0));
        step();
        sb_valid = 1'b0;

        // four weight beats to array 0, READY right after the last
        for (int b = 0; b < WR; b++) begin
            issue(1'b1, 1'b0, 0, 0, 32'h0100 + b, 32'hFFFF);
            @(negedge clk);
            check("lit_wready0", 64'(sa_weights_ready[0]), 64'(b == WR - 1));
            step();
        end

        // backpressure from array space blocks issue
        sa_fifo_has_space = 2'b01;
        sb_valid = 1'b1; sb_weight = 1'b1; sb_sa_sel = 1'b1;
        @(negedge clk);
        check("lit_no_space", 64'(sb_ready), 64'(0));
        step();
        sb_valid = 1'b0;
        sa_fifo_has_space = 2'b11;
        for (int b = 0; b < WR; b++) issue(1'b1, 1'b0, 1, 0, 32'h0200 + b, 32'h0);

        // fill array 1 with tags 5..8; a fifth push is blocked
        for (int k = 0; k < 4; k++) issue(1'b0, k[0], 1, 5 + k, 32'h1000 + k, 32'h2000 + k);
        sb_valid = 1'b1; sb_weight = 1'b0; sb_sa_sel = 1'b1; sb_vdst = 8'd9;
        @(negedge clk);
        check("lit_fifo_full", 64'(sb_ready), 64'(0));
        step();
        sb_valid = 1'b0;
        sa_out_valid = 2'b10;
        set_out(1, 32'hA000_0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lit_order_valid", 64'(wb_valid), 64'(1));
            check("lit_order_dst", 64'(wb_wbdst), 64'(5 + k));
            check("lit_order_id", 64'(wb_sa_id), 64'(1));
            step();
            set_out(1, 32'hA000_0001 + k);
        end
        sa_out_valid = 2'b00;

        // round-robin: both arrays with results, grants alternate
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 1'b0, 0, 10 + k, 32'h3000 + k, 32'h5555);
            issue(1'b0, 1'b1, 1, 20 + k, 32'h4000 + k, 32'h6666);
        end
        r0 = 3; r1 = 3;
        set_out(0, 32'hB0B0_0000);
        set_out(1, 32'hC1C1_0000);
        wb_output_ready = 1'b0;
        sa_out_valid = 2'b11;
        @(negedge clk);
        check("lit_stall_valid", 64'(wb_valid), 64'(1));
        check("lit_stall_id", 64'(wb_sa_id), 64'(0));
        check("lit_stall_ordy", 64'(sa_output_ready), 64'(0));
        step();
        wb_output_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("lit_rr_id", 64'(wb_sa_id), 64'(k % 2));
            check("lit_rr_dst", 64'(wb_wbdst), 64'((k % 2 == 0) ? 10 + k / 2 : 20 + k / 2));
            step();
            if (k % 2 == 0) r0--;
            else r1--;
            sa_out_valid = {r1 > 0, r0 > 0};
        end

        // weight reload waits for the pending tag to drain
        issue(1'b0, 1'b1, 0, 30, 32'h7000, 32'h7777);
        sb_valid = 1'b1; sb_weight = 1'b1; sb_sa_sel = 1'b0;
        @(negedge clk);
        check("lit_reload_blk1", 64'(sb_ready), 64'(0));
        step();
        @(negedge clk);
        check("lit_reload_blk2", 64'(sb_ready), 64'(0));
        step();
        sa_out_valid = 2'b01;
        @(negedge clk);
        check("lit_reload_wbdst", 64'(wb_wbdst), 64'(30));
        check("lit_reload_blk3", 64'(sb_ready), 64'(0));
        step();
        sa_out_valid = 2'b00;
        @(negedge clk);
        check("lit_reload_ok", 64'(sb_ready), 64'(1));
        step();
        sb_valid = 1'b0;

        // orphan result on array 1
        sa_out_valid = 2'b10;
        @(negedge clk);
        check("lit_orphan_ordy", 64'(sa_output_ready), 64'(2));
        check("lit_orphan_wbv", 64'(wb_valid), 64'(0));
        check("lit_orphan_err0", 64'(err_orphan), 64'(0));
        step();
        sa_out_valid = 2'b00;
        repeat (3) step();
        @(negedge clk);
        check("lit_orphan_sticky", 64'(err_orphan), 64'(1));
        step();

        // full FIFO frees space only the cycle after a pop
        for (int k = 0; k < 4; k++) issue(1'b0, 1'b0, 1, 40 + k, 32'h8000 + k, 32'h0);
        sa_out_valid = 2'b10;
        sb_valid = 1'b1; sb_weight = 1'b0; sb_sa_sel = 1'b1; sb_vdst = 8'd44;
        @(negedge clk);
        check("lit_full_pop_blk", 64'(sb_ready), 64'(0));
        check("lit_full_pop_dst", 64'(wb_wbdst), 64'(40));
        step();
        @(negedge clk);
        check("lit_full_pop_ok", 64'(sb_ready), 64'(1));
        check("lit_full_pop_dst2", 64'(wb_wbdst), 64'(41));
        step();
        sb_valid = 1'b0;
        sa_out_valid = 2'b00;

        // reset with three tags in flight on array 1
        sb_valid = 1'b1; sb_weight = 1'b1; sb_sa_sel = 1'b1;
        sa_out_valid = 2'b11;
        nRST = 1'b0;
        @(negedge clk);
        check("lit_rst2_ready", 64'(sb_ready), 64'(0));
        check("lit_rst2_wbv", 64'(wb_valid), 64'(0));
        check("lit_rst2_wrdy", 64'(sa_weights_ready), 64'(0));
        check("lit_rst2_err", 64'(err_orphan), 64'(0));
        step();
        nRST = 1'b1;
        sb_weight = 1'b0;
        sa_out_valid = 2'b10;
        @(negedge clk);
        check("lit_rst2_nowgt", 64'(sb_ready), 64'(0));
        check("lit_rst2_empty_ordy", 64'(sa_output_ready), 64'(2));
        check("lit_rst2_empty_wbv", 64'(wb_valid), 64'(0));
        step();
        sb_valid = 1'b0;
        sa_out_valid = 2'b00;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/gsau_multi_dispatch.md
GSAU_MULTI_DISPATCH -- requirements
Module: gsau_multi_dispatch

Interface
REQ-001 SHALL have parameter VEGGIEREGS, 256, vector register count; ENTRY_BITS = clog2(VEGGIEREGS).
REQ-002 SHALL have parameter NUM_SA, 2, number of systolic arrays (power of 2, >=2); SEL_W = clog2(NUM_SA).
REQ-003 SHALL have parameter ROW_W, 512, bits per array row/partial vector.
REQ-004 SHALL have parameter WEIGHT_ROWS, 32, weight beats per full weight load.
REQ-005 SHALL have parameter TAG_DEPTH, 64, tag FIFO entries per array (power of 2).
REQ-006 SHALL have ports, in order:
 CLK  in  1  clock, single domain
 nRST  in  1  asynchronous active-low reset
 sb_valid  in  1  scoreboard issue valid
 sb_ready  out  1  issue accepted when high with sb_valid
 sb_weight  in  1  1 = weight beat, 0 = input op
 sb_accum  in  1  input op uses veg_vdata2 partials; 0 = zero partials
 sb_sa_sel  in  SEL_W  target array
 sb_vdst  in  ENTRY_BITS  destination register of input op
 veg_vdata1  in  ROW_W  activations or weights
 veg_vdata2  in  ROW_W  partial sums
 sa_array_in  out  ROW_W  broadcast data to arrays
 sa_array_in_partials  out  ROW_W  broadcast partials
 sa_input_en, sa_weight_en, sa_partial_en  out  NUM_SA each  one-hot per-array strobes
 sa_fifo_has_space  in  NUM_SA  per-array input space
 sa_out_valid  in  NUM_SA  per-array result valid
 sa_array_output  in  NUM_SA*ROW_W  per-array result, array i at bits [i*ROW_W +: ROW_W]
 sa_output_ready  out  NUM_SA  per-array result consumed
 wb_valid  out  1  writeback valid
 wb_output_ready  in  1  writeback sink ready
 wb_wbdst  out  ENTRY_BITS  writeback register
 wb_psum  out  ROW_W  writeback data
 wb_sa_id  out  SEL_W  source array of writeback
 sa_weights_ready  out  NUM_SA  array in READY state
 err_orphan  out  1  sticky: result arrived with empty tag FIFO

Function
REQ-007 Per-array weight FSM SHALL have states NOWGT, LOADING, READY; reset state NOWGT.
REQ-008 An accepted weight beat SHALL move NOWGT->LOADING, or READY->LOADING if that array's tag FIFO is empty, with beat count set to 1.
REQ-009 In LOADING, each accepted weight beat SHALL increment the count; the beat at which count reaches WEIGHT_ROWS SHALL move the FSM to READY on the next edge.
REQ-010 sb_ready SHALL be combinational: high iff sa_fifo_has_space[sel] and the target accepts the op class; weight: NOWGT, LOADING, or READY with empty tag FIFO; input: READY and tag FIFO not full.
REQ-011 On handshake, weight: sa_weight_en[sel]=1; input: sa_input_en[sel]=sa_partial_en[sel]=1, push {sb_vdst} to tag FIFO[sel], same cycle, zero added latency.
REQ-012 sa_array_in SHALL equal veg_vdata1; sa_array_in_partials SHALL equal veg_vdata2 when sb_accum=1, else all zeros.
REQ-013 Writeback arbiter SHALL grant round-robin among arrays i with sa_out_valid[i] and tag FIFO[i] non-empty, starting after the last granted index (registered pointer, reset 0).
REQ-014 wb_valid = any candidate; wb_wbdst/wb_psum/wb_sa_id from granted array; sa_output_ready[g] = wb_output_ready; tag pop on wb_valid and wb_output_ready; pointer advances only on that transfer.
REQ-015 If sa_out_valid[i] and tag FIFO[i] empty, SHALL assert sa_output_ready[i] to drop the result, not assert wb_valid for it, and set err_orphan until reset.
REQ-016 Same-cycle push and pop on one FIFO SHALL leave occupancy unchanged; FIFO full with a pop that cycle SHALL still report not full only from next cycle (sb_ready uses registered full).
REQ-017 Pointer wrap SHALL be modulo TAG_DEPTH; arbiter pointer modulo NUM_SA.

Reset
REQ-018 While nRST low: all FSMs NOWGT, counts 0, FIFOs empty, pointer 0, err_orphan 0, all enables/ready/valid outputs 0; in-flight tags discarded mid-operation.

Structure
REQ-019 sys_arr_pkg SHALL hold NUM_SA, ROW_W, WEIGHT_ROWS defaults, weight-state enum and tag typedef.
REQ-020 Per-array tag storage SHALL be sub-module gsau_tag_fifo (register FIFO, ENTRY_BITS wide, TAG_DEPTH deep, full/empty flags), instantiated NUM_SA times.

Verification (NUM_SA=2, WEIGHT_ROWS=4, TAG_DEPTH=4)
REQ-021 Input to array 0 in NOWGT -> sb_ready=0; 4 weight beats -> sa_weights_ready[0]=1 one cycle after beat 4.
REQ-022 Push vdst 5,6,7,8 to array 1 -> 5th push blocked; outputs return 5,6,7,8 in order with wb_sa_id=1.
REQ-023 Both arrays out_valid every cycle, wb_output_ready=1 -> grants alternate 0,1,0,1.
REQ-024 Weight beat to READY array 0 with 1 tag pending -> sb_ready=0 until that writeback completes.
REQ-025 sa_out_valid[1] with empty FIFO -> sa_output_ready[1]=1, wb_valid=0, err_orphan=1 held.
REQ-026 nRST asserted with 3 tags in flight -> all outputs 0, FSMs NOWGT, FIFOs empty.
